// File: rtl/psum_pkg.sv
// psum_pkg: lane-slice helper and saturation limit helpers shared by the
// partial-sum accumulator files.
package psum_pkg;

  localparam int unsigned MAX_ACC_W = 64;

  // Bit offset of a lane inside a packed multi-lane word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  // Largest signed value for a given width, zero-extended to MAX_ACC_W.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int unsigned width);
    return (MAX_ACC_W'(1) << (width - 1)) - MAX_ACC_W'(1);
  endfunction

  // Most negative signed value for a given width (truncate to width at use).
  function automatic logic [MAX_ACC_W-1:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one write port, one read port with a registered
// (one-cycle) read. A same-cycle read of the address being written returns
// the old contents.
module simple_dual_port_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: per-entry, per-lane signed read-modify-write accumulator
// with one request per cycle, back-to-back hazard forwarding and a drain port.
// Optional build macro: ACC_SATURATE_EN (clamp lane sums, pulse o_sat).
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_first,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [LANES*IN_WIDTH-1:0]    i_data,
  input  logic                         i_rd_en,
  input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
  output logic                         o_rd_valid,
  output logic [LANES*ACC_WIDTH-1:0]   o_rd_data,
  output logic                         o_sat
);

  localparam int unsigned DATA_W = LANES * IN_WIDTH;
  localparam int unsigned WORD_W = LANES * ACC_WIDTH;
`ifdef ACC_SATURATE_EN
  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
`else
  localparam int unsigned SUM_W = ACC_WIDTH;
`endif

  logic                  accept;
  logic                  wr_en;
  logic                  s1_valid;
  logic                  s1_first;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_W-1:0]     s1_data;
  logic                  fwd_valid;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic [WORD_W-1:0]     fwd_data;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [WORD_W-1:0]     ram_rdata;
  logic [WORD_W-1:0]     old_word;
  logic [WORD_W-1:0]     new_word;
  logic signed [SUM_W-1:0] lane_in;
  logic signed [SUM_W-1:0] lane_old;
  logic signed [SUM_W-1:0] lane_sum;
  logic [ACC_WIDTH-1:0]    lane_res;
`ifdef ACC_SATURATE_EN
  logic                    sat_any;
`endif

  // Drain reads own the RAM read port.
  assign o_ready = ~i_rd_en;
  assign accept  = i_valid & o_ready;
  // A request caught in S1 by reset never writes.
  assign wr_en   = s1_valid & ~rst;

  simple_dual_port_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (s1_addr),
    .wdata (new_word),
    .re    (i_rd_en | accept),
    .raddr (i_rd_en ? i_rd_addr : i_addr),
    .rdata (ram_rdata)
  );

  // S1 valid bit.
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= accept;
  end

  // S1 payload captured on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_first <= i_first;
      s1_addr  <= i_addr;
      s1_data  <= i_data;
    end
  end

  // Forwarding register holds last cycle's write.
  always_ff @(posedge clk) begin
    if (rst) fwd_valid <= 1'b0;
    else     fwd_valid <= wr_en;
    if (wr_en) begin
      fwd_addr <= s1_addr;
      fwd_data <= new_word;
    end
  end

  // Drain response tracking.
  always_ff @(posedge clk) begin
    if (rst) o_rd_valid <= 1'b0;
    else     o_rd_valid <= i_rd_en;
    if (i_rd_en) rd_addr_q <= i_rd_addr;
  end

  // RAM read missed last cycle's write to the same entry; take it from fwd.
  assign old_word  = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : ram_rdata;
  assign o_rd_data = (fwd_valid && (fwd_addr == rd_addr_q)) ? fwd_data : ram_rdata;

  // Per-lane add/overwrite; lanes are computed separately so no carry crosses.
  always_comb begin
    new_word = '0;
    lane_in  = '0;
    lane_old = '0;
    lane_sum = '0;
    lane_res = '0;
`ifdef ACC_SATURATE_EN
    sat_any  = 1'b0;
`endif
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_in  = SUM_W'(signed'(s1_data[lane_lsb(k, IN_WIDTH) +: IN_WIDTH]));
      lane_old = SUM_W'(signed'(old_word[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH]));
      lane_sum = s1_first ? lane_in : lane_old + lane_in;
`ifdef ACC_SATURATE_EN
      if (lane_sum[SUM_W-1] != lane_sum[SUM_W-2]) begin
        sat_any  = 1'b1;
        lane_res = lane_sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
        lane_res = lane_sum[ACC_WIDTH-1:0];
      end
`else
      lane_res = lane_sum;
`endif
      new_word[lane_lsb(k, ACC_WIDTH) +: ACC_WIDTH] = lane_res;
    end
  end

`ifdef ACC_SATURATE_EN
  // Saturation pulse for the write just performed.
  always_ff @(posedge clk) begin
    if (rst) o_sat <= 1'b0;
    else     o_sat <= wr_en & sat_any;
  end
`else
  assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: table-driven vectors plus hand-written corner
// sequences for psum_accumulator; drain results go through a scoreboard.
module tb_psum_accumulator;

  logic         clk = 1'b0;
  logic         rst;

  logic         i_valid, i_first, i_rd_en;
  logic [7:0]   i_addr, i_rd_addr;
  logic [63:0]  i_data;
  logic         o_ready, o_rd_valid, o_sat;
  logic [127:0] o_rd_data;

  logic         b_valid, b_first, b_rd_en;
  logic [3:0]   b_addr, b_rd_addr;
  logic [63:0]  b_data;
  logic         b_ready, b_rd_valid, b_sat;
  logic [63:0]  b_rd_data;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_first(i_first), .i_addr(i_addr), .i_data(i_data),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid),
    .o_rd_data(o_rd_data), .o_sat(o_sat)
  );

  // Full-width inputs so a single write can sit at the 32-bit limit.
  psum_accumulator #(.ADDR_WIDTH(4), .LANES(2), .IN_WIDTH(32), .ACC_WIDTH(32)) dut_wide (
    .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_first(b_first), .i_addr(b_addr), .i_data(b_data),
    .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr), .o_rd_valid(b_rd_valid),
    .o_rd_data(b_rd_data), .o_sat(b_sat)
  );

  typedef struct {
    logic         is_rd;
    logic         first;
    logic [7:0]   addr;
    logic [63:0]  data;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] exp;
    int           due;
  } sb_t;

  vec_t vt[40];
  int   nv = 0;
  sb_t  sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef ACC_SATURATE_EN
  localparam logic [31:0] SAT_L0  = 32'h7FFF_FFFF;
  localparam logic        SAT_BIT = 1'b1;
`else
  localparam logic [31:0] SAT_L0  = 32'h8000_0000;
  localparam logic        SAT_BIT = 1'b0;
`endif

  function automatic logic [63:0] p16(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [127:0] p32(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare drain output against the scoreboard head, with exact latency.
  task automatic sb_check();
    sb_t e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (!o_rd_valid) chk("rd_valid missing", 128'(o_rd_valid), 128'(1));
      else             chk("rd_data", o_rd_data, e.exp);
    end else if (o_rd_valid) begin
      chk("rd_valid spurious", 128'(o_rd_valid), 128'(0));
    end
  endtask

  task automatic neg_phase();
    @(negedge clk);
    sb_check();
  endtask

  task automatic pos_phase();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    neg_phase();
    pos_phase();
  endtask

  task automatic add_acc(input logic first, input logic [7:0] addr, input logic [63:0] data);
    vt[nv] = '{is_rd: 1'b0, first: first, addr: addr, data: data, exp: '0};
    nv++;
  endtask

  task automatic add_rd(input logic [7:0] addr, input logic [127:0] exp);
    vt[nv] = '{is_rd: 1'b1, first: 1'b0, addr: addr, data: '0, exp: exp};
    nv++;
  endtask

  task automatic push_rd(input logic [7:0] addr, input logic [127:0] exp);
    i_rd_en   = 1'b1;
    i_rd_addr = addr;
    sb.push_back('{exp: exp, due: cyc + 1});
  endtask

  task automatic idle_a();
    i_valid = 1'b0; i_first = 1'b0; i_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_a(); i_addr = '0; i_data = '0; i_rd_addr = '0;
    b_valid = 1'b0; b_first = 1'b0; b_rd_en = 1'b0;
    b_addr = '0; b_data = '0; b_rd_addr = '0;

    // Vector table, applied back to back.
    add_acc(1'b1, 8'd3, p16(5, 100, -3, 0));
    add_acc(1'b0, 8'd3, p16(7, -200, -3, 1));
    add_rd(8'd3, p32(12, -100, -6, 1));
    add_acc(1'b1, 8'd0, p16(1, 1, 1, 1));
    for (int i = 0; i < 7; i++) add_acc(1'b0, 8'd0, p16(1, 1, 1, 1));
    add_rd(8'd0, p32(8, 8, 8, 8));
    add_acc(1'b1, 8'd5, p16('hFFFF, 'hFFFF, 0, 0));
    add_acc(1'b0, 8'd5, p16(1, 'hFFFF, 0, 0));
    add_rd(8'd5, p32(0, -2, 0, 0));
    add_acc(1'b1, 8'd10, p16(1000, 2000, 3000, 4000));
    add_acc(1'b1, 8'd11, p16(-1, -2, -3, -4));
    add_acc(1'b0, 8'd10, p16(1, 2, 3, 4));
    add_acc(1'b0, 8'd11, p16(-32768, 2, 3, 4));
    add_rd(8'd10, p32(1001, 2002, 3003, 4004));
    add_rd(8'd11, p32(-32769, 0, 0, 0));
    add_rd(8'd3, p32(12, -100, -6, 1));
    add_acc(1'b1, 8'd3, p16(2, 2, 2, 2));
    add_rd(8'd3, p32(2, 2, 2, 2));

    // Reset state.
    pos_phase();
    pos_phase();
    neg_phase();
    chk("reset o_rd_valid", 128'(o_rd_valid), 128'(0));
    chk("reset o_sat", 128'(o_sat), 128'(0));
    chk("reset o_ready", 128'(o_ready), 128'(1));
    pos_phase();
    rst = 1'b0;

    // Saturation / wrap at the lane limit on the wide instance.
    b_valid = 1'b1; b_first = 1'b1; b_addr = 4'd2; b_data = {32'd5, 32'h7FFF_FFFF};
    tick();
    b_first = 1'b0; b_data = {32'hFFFF_FFF6, 32'd1};
    tick();
    b_valid = 1'b0; b_rd_en = 1'b1; b_rd_addr = 4'd2;
    neg_phase();
    chk("wide o_sat after first", 128'(b_sat), 128'(0));
    pos_phase();
    b_rd_en = 1'b0;
    neg_phase();
    chk("wide o_sat on limit", 128'(b_sat), 128'(SAT_BIT));
    chk("wide rd_valid", 128'(b_rd_valid), 128'(1));
    chk("wide rd_data", 128'(b_rd_data), 128'({32'hFFFF_FFFB, SAT_L0}));
    pos_phase();
    neg_phase();
    chk("wide o_sat pulse end", 128'(b_sat), 128'(0));
    chk("wide rd_valid end", 128'(b_rd_valid), 128'(0));
    pos_phase();

    // Apply the vector table.
    for (int i = 0; i < nv; i++) begin
      idle_a();
      if (vt[i].is_rd) begin
        push_rd(vt[i].addr, vt[i].exp);
      end else begin
        i_valid = 1'b1; i_first = vt[i].first;
        i_addr = vt[i].addr; i_data = vt[i].data;
      end
      tick();
    end
    idle_a();
    tick();

    // Request collides with a drain read: held off one cycle, then accepted.
    i_valid = 1'b1; i_first = 1'b1; i_addr = 8'd20; i_data = p16(42, -42, 0, 7);
    push_rd(8'd3, p32(2, 2, 2, 2));
    #1;
    chk("o_ready during drain", 128'(o_ready), 128'(0));
    tick();
    i_rd_en = 1'b0;
    #1;
    chk("o_ready after drain", 128'(o_ready), 128'(1));
    tick();
    i_first = 1'b0; i_data = p16(1, 1, 1, 1);
    tick();
    idle_a();
    push_rd(8'd20, p32(43, -41, 1, 8));
    tick();
    idle_a();
    tick();

    // Reset lands while an add to entry 9 sits in S1.
    i_valid = 1'b1; i_first = 1'b1; i_addr = 8'd9; i_data = p16(9, 9, 9, 9);
    tick();
    idle_a();
    tick();
    i_valid = 1'b1; i_first = 1'b0; i_addr = 8'd9; i_data = p16(1, 1, 1, 1);
    tick();
    idle_a();
    rst = 1'b1;
    #1;
    chk("o_ready during reset", 128'(o_ready), 128'(1));
    tick();
    i_rd_en = 1'b1; i_rd_addr = 8'd9;
    tick();
    rst = 1'b0;
    idle_a();
    #1;
    chk("post-reset o_rd_valid", 128'(o_rd_valid), 128'(0));
    chk("post-reset o_sat", 128'(o_sat), 128'(0));
    push_rd(8'd9, p32(9, 9, 9, 9));
    tick();
    idle_a();
    tick();
    tick();

    if (sb.size() != 0) chk("scoreboard drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: depth of 2^ADDR_WIDTH entries.
REQ-002 SHALL have parameter LANES, default 4: number of parallel accumulator lanes per entry.
REQ-003 SHALL have parameter IN_WIDTH, default 16: signed input width per lane.
REQ-004 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width per lane, ACC_WIDTH >= IN_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_valid, input, 1 bit: accumulate request.
REQ-008 SHALL have port o_ready, output, 1 bit: request accepted when i_valid & o_ready.
REQ-009 SHALL have port i_first, input, 1 bit: overwrite the entry with the input instead of adding to it.
REQ-010 SHALL have port i_addr, input, ADDR_WIDTH bits: accumulate target entry.
REQ-011 SHALL have port i_data, input, LANES*IN_WIDTH bits: lane k in bits [k*IN_WIDTH +: IN_WIDTH].
REQ-012 SHALL have port i_rd_en, input, 1 bit: drain read request.
REQ-013 SHALL have port i_rd_addr, input, ADDR_WIDTH bits: drain read address.
REQ-014 SHALL have port o_rd_valid, output, 1 bit: o_rd_data valid.
REQ-015 SHALL have port o_rd_data, output, LANES*ACC_WIDTH bits: drained entry, lane k in bits [k*ACC_WIDTH +: ACC_WIDTH].
REQ-016 SHALL have port o_sat, output, 1 bit: one-cycle pulse when any lane saturated in the write cycle.

Function
REQ-017 SHALL drive o_ready = ~i_rd_en combinationally: a drain read takes the RAM read port and has priority.
REQ-018 SHALL, for a request accepted in cycle t, issue a RAM read of i_addr in t and register i_first, i_addr and i_data into stage S1.
REQ-019 SHALL, in cycle t+1, compute each lane's new value (first ? sext(in) : old + sext(in)) and write it to the RAM at S1 address in t+1.
REQ-020 SHALL take old from the forwarding register instead of the RAM output when the previous cycle's write had the same address (back-to-back hazard).
REQ-021 SHALL sustain one accepted request per cycle, including every cycle to the same address, with no lost updates.
REQ-022 SHALL return drain data with o_rd_valid one cycle after i_rd_en, and that data SHALL reflect any write completed in the same cycle as the read (write-to-read forwarding).
REQ-023 SHALL wrap modulo 2^ACC_WIDTH on overflow (two's complement) when ACC_SATURATE_EN is undefined.
REQ-024 SHALL treat lanes independently; a carry SHALL never propagate across lanes.

Reset
REQ-025 SHALL clear the S1 valid bit, the forwarding valid bit, o_rd_valid and o_sat to 0 on the clock edge where rst=1.
REQ-026 SHALL drop a request held in S1 when rst is asserted, so its write never occurs.
REQ-027 SHALL leave the RAM contents unchanged on reset; entries are initialised by i_first.
REQ-028 SHALL drive o_ready = 1 during and after reset, subject only to i_rd_en.

Configuration
REQ-029 SHALL, with ACC_SATURATE_EN defined, clamp each lane sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and pulse o_sat in the write cycle.
REQ-030 SHALL, without ACC_SATURATE_EN, wrap per REQ-023 and tie o_sat to 0.

Structure
REQ-031 SHALL keep the lane-slice helpers and saturation limit constants in a shared package, psum_pkg.
REQ-032 SHALL instantiate the existing simple_dual_port_ram (one-cycle registered read) as its only sub-module, with width LANES*ACC_WIDTH.

Verification
REQ-033 SHALL test that first-write of 5 to addr 3, then add 7, then drain addr 3 -> o_rd_data lane0 = 12, one cycle after i_rd_en.
REQ-034 SHALL test 8 consecutive requests to addr 0 (first=1 with 1, then adds of 1) -> drain returns 8 on all lanes.
REQ-035 SHALL test i_valid=1 with i_rd_en=1 in the same cycle -> o_ready=0 and the request is held by the bench and accepted next cycle with its correct result.
REQ-036 SHALL test lane0 = 0x7FFFFFFF plus 1: without the macro -> 0x80000000 and o_sat=0; with ACC_SATURATE_EN -> 0x7FFFFFFF and o_sat=1 for one cycle.
REQ-037 SHALL test rst asserted the cycle after accepting an add to addr 9 -> addr 9 unchanged on drain, and o_rd_valid=0 and o_sat=0 after reset.
REQ-038 SHALL test lane1 = -1 plus -1 with lane0 = 0xFFFF inputs -> lane1 = -2, and no corruption of lane0.
